// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared switch counts and sizing helper for the switch debouncer
package sw_debounce_pkg;

   localparam int SW_NUM_NAV  = 5;
   localparam int SW_NUM_USER = 8;
   localparam int SW_NUM_SEL  = 3;
   localparam int SW_WIDTH    = SW_NUM_NAV + SW_NUM_USER + SW_NUM_SEL;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - single-bit sample filter with level and edge-pulse registers
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int StableSamples = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic s_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int              CW   = cnt_width(StableSamples + 1);
   localparam logic [CW-1:0]   LAST = CW'(StableSamples - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Next state: count disagreeing samples, accept on the last one, abort on agreement.
   always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (tick_i) begin
         if (s_i == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q == LAST) begin
            lvl_d  = s_i;
            cnt_d  = '0;
            rise_d = s_i;
            fall_d = ~s_i;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Filter state and edge pulses, all cleared by reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         lvl_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - synchronises and debounces switch pins with a shared sample prescaler
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int               Width         = SW_WIDTH,
   parameter int               SysClkFreq    = 30_000_000,
   parameter int               SampleFreq    = 1_000,
   parameter int               StableSamples = 4,
   parameter logic [Width-1:0] InvertMask    = '1
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_ni,
   input  logic [Width-1:0] sw_raw_i,
   output logic [Width-1:0] sw_o,
   output logic [Width-1:0] sw_rise_o,
   output logic [Width-1:0] sw_fall_o,
   output logic             sample_tick_o
);

   localparam int Div = SysClkFreq / SampleFreq;
   localparam int PW  = cnt_width(Div);

   if (Div < 2) begin : g_div_check
      $error("sw_debounce: SysClkFreq / SampleFreq must be at least 2");
   end
   if (StableSamples < 1 || StableSamples > 255) begin : g_ss_check
      $error("sw_debounce: StableSamples must be in 1..255");
   end

   logic [Width-1:0] sync1_q, sync2_q;
   logic [Width-1:0] s;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             tick;

   // Two-flop synchroniser on the asynchronous pins.
   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_raw_i;
         sync2_q <= sync1_q;
      end
   end

   assign s    = sync2_q ^ InvertMask;
   assign tick = (pcnt_q == PW'(Div - 1));

   // Prescaler wraps to zero on the tick cycle.
   always_comb begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
   end

   // Prescaler register.
   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

   assign sample_tick_o = tick;

   for (genvar i = 0; i < Width; i++) begin : g_bit
      sw_debounce_bit #(
         .StableSamples(StableSamples)
      ) u_bit (
         .clk_i (clk_sys_i),
         .rst_ni(rst_sys_ni),
         .tick_i(tick),
         .s_i   (s[i]),
         .lvl_o (sw_o[i]),
         .rise_o(sw_rise_o[i]),
         .fall_o(sw_fall_o[i])
      );
   end

endmodule
